// File: rtl/alu_serial_rx.sv
// alu_serial_rx: deserialises ALU packets (B, A, CMD frame) with CRC-4 and opcode checks
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   sin               serial input, idles high
//   a, b, op          operands and opcode of the last good packet
//   pkt_valid         one-cycle pulse when a/b/op are updated
//   err_valid         one-cycle pulse when a packet is rejected
//   err_flags         {ERR_DATA, ERR_CRC, ERR_OP}, one-hot while err_valid
module alu_serial_rx #(
    parameter int N_BYTES      = 4,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sin,
    output logic [8*N_BYTES-1:0]   a,
    output logic [8*N_BYTES-1:0]   b,
    output logic [2:0]             op,
    output logic                   pkt_valid,
    output logic                   err_valid,
    output logic [2:0]             err_flags
);
    localparam int DW = 8 * N_BYTES;
    localparam int CW = $clog2(2 * N_BYTES + 2);
    localparam logic [CW-1:0] NFR  = CW'(2 * N_BYTES);
    localparam logic [CW-1:0] NSAT = CW'(2 * N_BYTES + 1);
    localparam logic [4:0] LAST = 5'(CLKS_PER_BIT - 1);
    // Preloading the tick counter in START lands the start-bit sample CLKS_PER_BIT/2
    // cycles after the falling edge while every later sample reuses the LAST compare.
    localparam logic [4:0] TICK0 = (CLKS_PER_BIT == 1) ? 5'd0 : 5'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {IDLE, START, FLAG, BITS, STOP} state_t;

    state_t          state;
    logic [4:0]      tick;
    logic [2:0]      bit_cnt;
    logic            flag;
    logic [7:0]      pay;
    logic [2*DW-1:0] sr;
    logic [CW-1:0]   dcnt;
    logic            bad_frame;
    logic [3:0]      crc;
    logic            sample;
    logic [3:0]      crc_fin;

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        return {c[2:0], 1'b0} ^ ((c[3] ^ d) ? 4'b0011 : 4'b0000);
    endfunction

    function automatic logic [3:0] crc_byte(input logic [3:0] c, input logic [7:0] d);
        logic [3:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = crc_step(r, d[i]);
        return r;
    endfunction

    assign sample  = tick == LAST;
    // CRC tail covers the marker bit and the received opcode from the CMD payload
    assign crc_fin = crc_step(crc_step(crc_step(crc_step(crc, 1'b1), pay[6]), pay[5]), pay[4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            flag      <= 1'b0;
            pay       <= '0;
            sr        <= '0;
            dcnt      <= '0;
            bad_frame <= 1'b0;
            crc       <= '0;
            a         <= '0;
            b         <= '0;
            op        <= '0;
            pkt_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
        end else begin
            pkt_valid <= 1'b0;
            err_valid <= 1'b0;
            err_flags <= '0;
            case (state)
                IDLE: if (!sin) begin
                    tick    <= TICK0;
                    bit_cnt <= '0;
                    state   <= (CLKS_PER_BIT == 1) ? FLAG : START;
                end
                START: if (sample) begin
                    tick  <= '0;
                    state <= sin ? IDLE : FLAG;
                end else tick <= tick + 5'd1;
                FLAG: if (sample) begin
                    tick  <= '0;
                    flag  <= sin;
                    state <= BITS;
                end else tick <= tick + 5'd1;
                BITS: if (sample) begin
                    tick    <= '0;
                    pay     <= {pay[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end else tick <= tick + 5'd1;
                STOP: if (sample) begin
                    tick  <= '0;
                    state <= IDLE;
                    if (flag) begin
                        // A CMD frame always ends the packet, even with a broken stop bit
                        if (!sin || bad_frame || dcnt != NFR) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b100;
                        end else if (pay[3:0] != crc_fin) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b010;
                        end else if (pay[5]) begin
                            err_valid <= 1'b1;
                            err_flags <= 3'b001;
                        end else begin
                            pkt_valid <= 1'b1;
                            b         <= sr[2*DW-1:DW];
                            a         <= sr[DW-1:0];
                            op        <= pay[6:4];
                        end
                        dcnt      <= '0;
                        bad_frame <= 1'b0;
                        crc       <= '0;
                    end else if (!sin) begin
                        bad_frame <= 1'b1;
                    end else begin
                        sr  <= {sr[2*DW-9:0], pay};
                        crc <= crc_byte(crc, pay);
                        if (dcnt != NSAT) dcnt <= dcnt + CW'(1);
                    end
                end else tick <= tick + 5'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_rx.sv
// tb_alu_serial_rx: scoreboard bench for two alu_serial_rx builds (4 bytes/1x, 2 bytes/4x)
module tb_alu_serial_rx;
    logic        clk = 1'b0;
    logic        rst0_n, rst1_n, sin0, sin1;
    logic [31:0] a0, b0;
    logic [2:0]  op0, fl0;
    logic        pv0, ev0;
    logic [15:0] a1, b1;
    logic [2:0]  op1, fl1;
    logic        pv1, ev1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    alu_serial_rx #(.N_BYTES(4), .CLKS_PER_BIT(1)) u4 (
        .clk(clk), .rst_n(rst0_n), .sin(sin0), .a(a0), .b(b0), .op(op0),
        .pkt_valid(pv0), .err_valid(ev0), .err_flags(fl0)
    );

    alu_serial_rx #(.N_BYTES(2), .CLKS_PER_BIT(4)) u2 (
        .clk(clk), .rst_n(rst1_n), .sin(sin1), .a(a1), .b(b1), .op(op1),
        .pkt_valid(pv1), .err_valid(ev1), .err_flags(fl1)
    );

    typedef struct {
        bit          err;
        logic [2:0]  flags;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ha[2];
    logic [31:0] hb[2];
    logic [2:0]  ho[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference CRC by polynomial long division of {B, A, 1, OP} * x^4 by x^4+x+1
    function automatic logic [4:0] div_bit(input logic [4:0] r, input logic d);
        logic [4:0] t;
        t = {r[3:0], d};
        return t[4] ? t ^ 5'b10011 : t;
    endfunction

    function automatic logic [3:0] crc_ref(input logic [31:0] bv, input logic [31:0] av,
                                           input int nb, input logic [2:0] o);
        logic [4:0] r;
        r = '0;
        for (int i = 8 * nb - 1; i >= 0; i--) r = div_bit(r, bv[i]);
        for (int i = 8 * nb - 1; i >= 0; i--) r = div_bit(r, av[i]);
        r = div_bit(r, 1'b1);
        for (int i = 2; i >= 0; i--) r = div_bit(r, o[i]);
        for (int i = 0; i < 4; i++) r = div_bit(r, 1'b0);
        return r[3:0];
    endfunction

    task automatic drive(input int d, input logic v);
        if (d == 0) sin0 = v;
        else sin1 = v;
        repeat (d == 0 ? 1 : 4) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        repeat (n) drive(d, 1'b1);
    endtask

    task automatic frame(input int d, input logic fl, input logic [7:0] by, input logic stp);
        drive(d, 1'b0);
        drive(d, fl);
        for (int i = 7; i >= 0; i--) drive(d, by[i]);
        drive(d, stp);
    endtask

    task automatic packet(input int d, input logic [31:0] bv, input logic [31:0] av,
                          input logic [2:0] o, input logic [3:0] cx, input int nfr, input int bad);
        int nb;
        logic [7:0] by;
        nb = (d == 0) ? 4 : 2;
        for (int i = 0; i < nfr; i++) begin
            by = (i < nb) ? bv[8*(nb-1-i) +: 8] : av[8*(2*nb-1-i) +: 8];
            frame(d, 1'b0, by, i != bad);
        end
        frame(d, 1'b1, {1'b0, o, crc_ref(bv, av, nb, o) ^ cx}, 1'b1);
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic exp_pkt(input int d, input logic [31:0] bv, input logic [31:0] av, input logic [2:0] o);
        ha[d] = av;
        hb[d] = bv;
        ho[d] = o;
        push(d, '{1'b0, 3'b000, av, bv, o});
    endtask

    task automatic exp_err(input int d, input logic [2:0] f);
        push(d, '{1'b1, f, ha[d], hb[d], ho[d]});
    endtask

    task automatic mon(input int d, input logic pv, input logic ev, input logic [2:0] fl,
                       input logic [31:0] av, input logic [31:0] bv, input logic [2:0] o);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d_unexpected_pulse: got pkt_valid=%b err_valid=%b expected no pulse", d, pv, ev);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk($sformatf("dut%0d_pkt_err", d), {62'b0, pv, ev}, e.err ? 64'd1 : 64'd2);
        if (e.err) chk($sformatf("dut%0d_err_flags", d), {61'b0, fl}, {61'b0, e.flags});
        chk($sformatf("dut%0d_a", d), {32'b0, av}, {32'b0, e.a});
        chk($sformatf("dut%0d_b", d), {32'b0, bv}, {32'b0, e.b});
        chk($sformatf("dut%0d_op", d), {61'b0, o}, {61'b0, e.op});
    endtask

    initial forever begin
        @(negedge clk);
        if (pv0 || ev0) mon(0, pv0, ev0, fl0, a0, b0, op0);
        if (pv1 || ev1) mon(1, pv1, ev1, fl1, {16'b0, a1}, {16'b0, b1}, op1);
    end

    initial begin
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        sin0   = 1'b1;
        sin1   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ha[i] = '0;
            hb[i] = '0;
            ho[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a", {32'b0, a0}, 64'd0);
        chk("rst_b", {32'b0, b0}, 64'd0);
        chk("rst_op", {61'b0, op0}, 64'd0);
        chk("rst_valids", {61'b0, pv0, ev0, 1'b0}, 64'd0);
        chk("rst_flags", {61'b0, fl0}, 64'd0);
        chk("rst_u2_ab", {32'b0, a1, b1}, 64'd0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        idle(0, 3);

        exp_pkt(0, 32'h0000000A, 32'h00000003, 3'b101);
        packet(0, 32'h0000000A, 32'h00000003, 3'b101, 4'b0000, 8, -1);
        idle(0, 3);
        exp_err(0, 3'b010);
        packet(0, 32'h0000000A, 32'h00000003, 3'b101, 4'b0001, 8, -1);
        idle(0, 3);
        exp_err(0, 3'b001);
        packet(0, 32'h11223344, 32'h55667788, 3'b111, 4'b0000, 8, -1);
        idle(0, 3);
        exp_pkt(0, 32'hFF00FF00, 32'h0F0F0F0F, 3'b000);
        packet(0, 32'hFF00FF00, 32'h0F0F0F0F, 3'b000, 4'b0000, 8, -1);
        idle(0, 3);
        exp_err(0, 3'b100);
        packet(0, 32'hCAFEF00D, 32'h12345678, 3'b001, 4'b0000, 7, -1);
        idle(0, 3);
        exp_err(0, 3'b100);
        packet(0, 32'hCAFEF00D, 32'h12345678, 3'b001, 4'b0000, 8, 2);
        idle(0, 3);
        exp_pkt(0, 32'h00000001, 32'hDEADBEEF, 3'b001);
        packet(0, 32'h00000001, 32'hDEADBEEF, 3'b001, 4'b0000, 8, -1);
        idle(0, 3);

        sin1 = 1'b0;
        @(posedge clk);
        #1;
        sin1 = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("glitch_u2_ab", {32'b0, a1, b1}, 64'd0);
        exp_pkt(1, 32'h1234, 32'h0001, 3'b100);
        exp_pkt(1, 32'hFFFF, 32'h0001, 3'b100);
        packet(1, 32'h1234, 32'h0001, 3'b100, 4'b0000, 4, -1);
        packet(1, 32'hFFFF, 32'h0001, 3'b100, 4'b0000, 4, -1);
        idle(1, 3);

        for (int i = 0; i < 4; i++) frame(0, 1'b0, 8'h5A, 1'b1);
        drive(0, 1'b0);
        drive(0, 1'b0);
        drive(0, 1'b1);
        drive(0, 1'b1);
        rst0_n = 1'b0;
        ha[0] = '0;
        hb[0] = '0;
        ho[0] = '0;
        @(negedge clk);
        chk("midrst_a", {32'b0, a0}, 64'd0);
        chk("midrst_b", {32'b0, b0}, 64'd0);
        chk("midrst_op_valids_flags", {56'b0, op0, pv0, ev0, fl0}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        sin0   = 1'b1;
        rst0_n = 1'b1;
        idle(0, 3);
        exp_pkt(0, 32'h0000F0F0, 32'h00000F0F, 3'b001);
        packet(0, 32'h0000F0F0, 32'h00000F0F, 3'b001, 4'b0000, 8, -1);
        idle(0, 6);

        chk("u4_pending_responses", 64'(q0.size()), 64'd0);
        chk("u2_pending_responses", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
